// File: rtl/fetch_ctrl_pkg.sv
// Shared constants, state encoding and event ranking for the fetch sequencer.
package fetch_ctrl_pkg;

  localparam logic [31:0] PC_BEGIN = 32'h0000_3000;
  localparam logic [31:0] PC_EXC   = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Larger rank wins; 0 means no PC-changing event this cycle.
  function automatic logic [1:0] event_rank(input logic int_req, input logic eret,
                                            input logic redirect);
    if (int_req)       return 2'd3;
    else if (eret)     return 2'd2;
    else if (redirect) return 2'd1;
    else               return 2'd0;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction buffer used while the decode stage is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        drop_i,
  input  logic        unload_i,
  input  logic [31:0] word_i,
  output logic        valid_o,
  output logic [31:0] word_o
);

  logic        valid_q;
  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      word_q  <= 32'h0;
    end else if (drop_i || unload_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      word_q  <= word_i;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, the imem handshake and the IF/ID register.
// States: ST_REQ issue/await fetch | ST_HOLD word buffered under stall | ST_DRAIN kill outstanding fetch
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter logic [31:0] PC_RESET   = PC_BEGIN,
  parameter logic [31:0] EXC_VECTOR = PC_EXC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  input  logic         int_req_i,
  input  logic         eret_i,
  input  logic [31:0]  epc_i,
  fetch_ctrl_if.master im,
  output logic [31:0]  pc_o,
  output logic         f_valid_o,
  output logic [31:0]  f_instr_o,
  output logic [31:0]  f_pc_o
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pend_q;
  logic [1:0]   pend_rank_q;
  logic         f_valid_q;
  logic [31:0]  f_instr_q;
  logic [31:0]  f_pc_q;

  logic [1:0]   rank;
  logic         ev;
  logic [31:0]  tgt;
  logic         pend_take;
  logic         deliver;
  logic [31:0]  dword;
  logic         buf_load;
  logic         buf_drop;
  logic         buf_unload;
  logic         buf_valid;
  logic [31:0]  buf_word;

  always_comb begin
    rank      = event_rank(int_req_i, eret_i, redirect_i);
    ev        = (rank != 2'd0);
    tgt       = int_req_i ? EXC_VECTOR : (eret_i ? epc_i : redirect_pc_i);
    pend_take = ev && (rank >= pend_rank_q);
  end

  always_comb begin
    deliver    = 1'b0;
    dword      = im.rdata;
    buf_load   = 1'b0;
    buf_drop   = 1'b0;
    buf_unload = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (im.ack && !ev) begin
          if (stall_i) buf_load = 1'b1;
          else         deliver  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ev) begin
          buf_drop = 1'b1;
        end else if (!stall_i && buf_valid) begin
          deliver    = 1'b1;
          buf_unload = 1'b1;
          dword      = buf_word;
        end
      end
      default: ;
    endcase
  end

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .load_i   (buf_load),
    .drop_i   (buf_drop),
    .unload_i (buf_unload),
    .word_i   (im.rdata),
    .valid_o  (buf_valid),
    .word_o   (buf_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_REQ;
      pc_q        <= PC_RESET;
      pend_q      <= 32'h0;
      pend_rank_q <= 2'd0;
      f_valid_q   <= 1'b0;
      f_instr_q   <= 32'h0;
      f_pc_q      <= 32'h0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (im.ack) begin
            if (ev)            pc_q    <= tgt;
            else if (!stall_i) pc_q    <= pc_q + 32'd4;
            else               state_q <= ST_HOLD;
          end else if (ev) begin
            pend_q      <= tgt;
            pend_rank_q <= rank;
            state_q     <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (ev) begin
            pc_q    <= tgt;
            state_q <= ST_REQ;
          end else if (deliver) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          // A higher-or-equal event arriving with the killing ack still wins.
          if (im.ack) begin
            pc_q    <= pend_take ? tgt : pend_q;
            state_q <= ST_REQ;
          end else if (pend_take) begin
            pend_q      <= tgt;
            pend_rank_q <= rank;
          end
        end
        default: state_q <= ST_REQ;
      endcase

      if (int_req_i) begin
        f_valid_q <= 1'b0;
      end else if (!stall_i) begin
        f_valid_q <= deliver;
        if (deliver) begin
          f_instr_q <= dword;
          f_pc_q    <= pc_q;
        end
      end
    end
  end

  assign im.req    = reset && (state_q != ST_HOLD);
  assign im.addr   = pc_q;
  assign pc_o      = pc_q;
  assign f_valid_o = f_valid_q;
  assign f_instr_o = f_instr_q;
  assign f_pc_o    = f_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random stimulus for fetch_ctrl against a per-cycle behavioural model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        int_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] pc, f_instr, f_pc;
  logic        f_valid;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  int wcnt = 0;

  fetch_ctrl_if imb ();

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .int_req_i     (int_req),
    .eret_i        (eret),
    .epc_i         (epc),
    .im            (imb.master),
    .pc_o          (pc),
    .f_valid_o     (f_valid),
    .f_instr_o     (f_instr),
    .f_pc_o        (f_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  // Memory: acks once a request has waited at least lat cycles.
  always_comb begin
    imb.ack   = imb.req && (wcnt >= lat);
    imb.rdata = instr_of(imb.addr);
  end

  always @(posedge clk) begin
    if (!imb.req || imb.ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: what the pipeline front end must show after each edge.
  logic        m_ok = 1'b0;
  logic [31:0] m_pc, m_buf, m_pend, m_fi, m_fp;
  logic        m_hold, m_drain, m_fv;
  int          m_prank;

  always @(negedge clk) begin
    int          r;
    logic [31:0] t;
    logic        dlv;
    logic [31:0] dw, dp;
    if (m_ok) begin
      chk("im_req", {31'b0, imb.req}, {31'b0, reset && !m_hold});
      if (reset && !m_hold) chk("im_addr", imb.addr, m_pc);
      chk("pc", pc, m_pc);
      chk("f_valid", {31'b0, f_valid}, {31'b0, m_fv});
      chk("f_instr", f_instr, m_fi);
      chk("f_pc", f_pc, m_fp);
    end
    if (!reset) begin
      m_pc = 32'h3000; m_buf = 0; m_pend = 0; m_prank = 0;
      m_hold = 0; m_drain = 0; m_fv = 0; m_fi = 0; m_fp = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      r   = int_req ? 3 : eret ? 2 : redirect ? 1 : 0;
      t   = int_req ? 32'h4180 : eret ? epc : redirect_pc;
      dlv = 0; dw = 0; dp = 0;
      if (m_hold) begin
        if (r != 0) begin m_hold = 0; m_pc = t; end
        else if (!stall) begin dlv = 1; dw = m_buf; dp = m_pc; m_pc += 4; m_hold = 0; end
      end else if (m_drain) begin
        if (r != 0 && r >= m_prank) begin m_pend = t; m_prank = r; end
        if (imb.ack) begin m_pc = m_pend; m_drain = 0; end
      end else if (imb.ack) begin
        if (r != 0) m_pc = t;
        else if (!stall) begin dlv = 1; dw = instr_of(m_pc); dp = m_pc; m_pc += 4; end
        else begin m_hold = 1; m_buf = instr_of(m_pc); end
      end else if (r != 0) begin
        m_drain = 1; m_pend = t; m_prank = r;
      end
      if (int_req) m_fv = 0;
      else if (!stall) begin
        m_fv = dlv;
        if (dlv) begin m_fi = dw; m_fp = dp; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Leaves the bench one step into the first cycle after reset release.
  task automatic start(input int l);
    reset = 0; stall = 0; redirect = 0; int_req = 0; eret = 0;
    lat = l;
    cyc(); cyc();
    reset = 1;
  endtask

  initial begin
    // Zero-wait streaming
    start(0);
    #1 chk("s1 req", {31'b0, imb.req}, 32'd1); chk("s1 a0", imb.addr, 32'h3000);
    chk("s1 fv0", {31'b0, f_valid}, 32'd0);
    cyc(); #1 chk("s1 a1", imb.addr, 32'h3004); chk("s1 fv1", {31'b0, f_valid}, 32'd1);
    chk("s1 fpc1", f_pc, 32'h3000);
    cyc(); #1 chk("s1 a2", imb.addr, 32'h3008); chk("s1 fpc2", f_pc, 32'h3004);
    chk("s1 fi2", f_instr, 32'h8C00_3004);

    // Three-wait fetch holds the request stable
    start(3);
    for (int i = 0; i < 3; i++) begin
      #1 chk("s2 req", {31'b0, imb.req}, 32'd1); chk("s2 addr", imb.addr, 32'h3000);
      chk("s2 fv", {31'b0, f_valid}, 32'd0);
      cyc();
    end
    #1 chk("s2 ack addr", imb.addr, 32'h3000);
    cyc(); #1 chk("s2 fv", {31'b0, f_valid}, 32'd1); chk("s2 fpc", f_pc, 32'h3000);
    cyc(); #1 chk("s2 pulse end", {31'b0, f_valid}, 32'd0);

    // Redirect during a two-wait fetch of 0x3008
    start(0);
    cyc(); cyc();
    lat = 2; redirect = 1; redirect_pc = 32'h3100;
    #1 chk("s3 a", imb.addr, 32'h3008);
    cyc(); redirect = 0;
    #1 chk("s3 drain req", {31'b0, imb.req}, 32'd1); chk("s3 drain addr", imb.addr, 32'h3008);
    cyc(); #1 chk("s3 drain addr2", imb.addr, 32'h3008);
    cyc(); #1 chk("s3 new addr", imb.addr, 32'h3100); chk("s3 fv", {31'b0, f_valid}, 32'd0);
    cyc(); cyc(); cyc();
    #1 chk("s3 fpc", f_pc, 32'h3100); chk("s3 fv2", {31'b0, f_valid}, 32'd1);

    // Stall at the ack of 0x300C
    start(0);
    cyc(); cyc(); cyc();
    stall = 1;
    #1 chk("s4 a", imb.addr, 32'h300C); chk("s4 fpc", f_pc, 32'h3008);
    cyc(); #1 chk("s4 hold req", {31'b0, imb.req}, 32'd0); chk("s4 hold fpc", f_pc, 32'h3008);
    chk("s4 hold fv", {31'b0, f_valid}, 32'd1);
    cyc(); stall = 0;
    #1 chk("s4 hold req2", {31'b0, imb.req}, 32'd0);
    cyc(); #1 chk("s4 fpc2", f_pc, 32'h300C); chk("s4 fi2", f_instr, 32'h8C00_300C);
    chk("s4 next", imb.addr, 32'h3010); chk("s4 req", {31'b0, imb.req}, 32'd1);

    // Interrupt beats eret, and kills f_valid under stall
    start(0);
    cyc(); int_req = 1; stall = 1; eret = 1; epc = 32'h0000_5550;
    #1 chk("s5 fv pre", {31'b0, f_valid}, 32'd1);
    cyc(); int_req = 0; eret = 0; stall = 0;
    #1 chk("s5 fv", {31'b0, f_valid}, 32'd0); chk("s5 addr", imb.addr, 32'h4180);

    // eret while holding a buffered word
    start(0);
    stall = 1;
    cyc(); stall = 0; eret = 1; epc = 32'h3040;
    #1 chk("s6 hold req", {31'b0, imb.req}, 32'd0);
    cyc(); eret = 0;
    #1 chk("s6 addr", imb.addr, 32'h3040); chk("s6 fv", {31'b0, f_valid}, 32'd0);
    cyc(); #1 chk("s6 fpc", f_pc, 32'h3040);

    // Reset mid-DRAIN
    start(2);
    redirect = 1; redirect_pc = 32'h3100;
    cyc(); redirect = 0;
    #1 chk("s7 drain addr", imb.addr, 32'h3000);
    cyc(); reset = 0;
    #1 chk("s7 req low", {31'b0, imb.req}, 32'd0);
    cyc(); #1 chk("s7 pc", pc, 32'h3000); chk("s7 req", {31'b0, imb.req}, 32'd0);
    reset = 1;
    cyc(); cyc(); cyc(); cyc();

    // PC wrap, then redirect coincident with stall
    start(0);
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); redirect = 0;
    #1 chk("s8 addr", imb.addr, 32'hFFFF_FFFC);
    cyc(); redirect = 1; redirect_pc = 32'h3200; stall = 1;
    #1 chk("s8 wrap", imb.addr, 32'h0); chk("s8 fpc", f_pc, 32'hFFFF_FFFC);
    cyc(); redirect = 0;
    #1 chk("s8 redir", imb.addr, 32'h3200); chk("s8 fhold", f_pc, 32'hFFFF_FFFC);
    cyc(); stall = 0;
    cyc(); #1 chk("s8 fpc2", f_pc, 32'h3200);

    // Random mix, checked by the model every cycle
    start(1);
    for (int i = 0; i < 400; i++) begin
      cyc();
      lat         = $urandom_range(0, 2);
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = {$urandom_range(0, 32'h0000_FFFF), 2'b00};
      int_req     = ($urandom_range(0, 24) == 0);
      eret        = ($urandom_range(0, 19) == 0);
      epc         = {$urandom_range(0, 32'h0000_FFFF), 2'b00};
      reset       = ($urandom_range(0, 49) != 0);
    end
    cyc();
    reset = 1; stall = 0; redirect = 0; int_req = 0; eret = 0;
    cyc(); cyc();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the five-stage MIPS pipeline. Owns the fetch PC and the instruction-memory request handshake, and produces the IF/ID instruction stream. It arbitrates every PC-changing event: reset, interrupt/exception entry, eret, D-stage branch/jump redirect, hazard stall and sequential +4. Memory may take a variable number of cycles, so in-flight fetches are tracked and killed here.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC after reset
- EXC_VECTOR, 32'h0000_4180, handler entry PC on int_req

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low
- stall  in  1  D-stage hazard stall; IF/ID outputs must hold
- redirect  in  1  D-stage branch/jump taken
- redirect_pc  in  32  target for redirect
- int_req  in  1  CP0 interrupt/exception request
- eret  in  1  eret in D stage
- epc  in  32  return PC from CP0
- im_req  out  1  memory request
- im_addr  out  32  request address
- im_ack  in  1  memory response valid; may be the same cycle as im_req
- im_rdata  in  32  instruction word, valid with im_ack
- pc  out  32  current fetch PC
- f_valid  out  1  IF/ID instruction valid
- f_instr  out  32  IF/ID instruction
- f_pc  out  32  PC of f_instr

## Operation
- Event priority: reset > int_req > eret > redirect > stall > sequential. The winning event sets target T: EXC_VECTOR, epc, redirect_pc, or none.
- States:
  - REQ: im_req=1, im_addr=pc.
  - HOLD: im_req=0; a fetched word is buffered.
  - DRAIN: im_req=1, im_addr=pc; the outstanding fetch is killed.
- Handshake rule: once im_req is asserted, im_req and im_addr stay stable until im_ack. The only exception is reset.
- REQ, ack, event: discard im_rdata; pc<=T; stay in REQ.
- REQ, ack, no event, !stall: f_instr<=im_rdata; f_pc<=pc; f_valid<=1; pc<=pc+4.
- REQ, ack, no event, stall: buffer<=im_rdata; go to HOLD. pc is unchanged.
- REQ, no ack, event: pend<=T; go to DRAIN.
- DRAIN, no ack: a new event overwrites pend only if it has higher or equal priority.
- DRAIN, ack: discard the data; pc<=pend; go to REQ.
- HOLD, event: drop the buffer; pc<=T; go to REQ.
- HOLD, no event, !stall: f_* <= buffer, with f_pc=pc; pc<=pc+4; go to REQ.
- IF/ID outputs:
  - On any cycle where stall=1, f_* hold.
  - On any cycle where stall=0 and no word is delivered, f_valid<=0 (bubble).
  - int_req forces f_valid<=0 even when stall=1.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No alignment checking (CP0's job). Targets pass through unmodified.

## Timing
- Reset values: pc=PC_RESET, f_valid=0, f_instr=0, f_pc=0, state=REQ, pend=0, buffer=0. im_req=0 while reset=0.
- im_req rises in the first cycle after reset deasserts.
- Zero-wait memory (same-cycle ack): one instruction per cycle, f_valid is registered (1-cycle latency from ack).
- N-wait memory: f_valid rises the cycle after the ack.
- An event coincident with an ack takes effect next cycle with no DRAIN. pc=T one cycle after the event.
- Reset during DRAIN or HOLD: abandon the transaction; the memory side tolerates the dropped im_req.
- Redirect and stall together: redirect wins; the new fetch starts, and f_* hold until stall drops.

## Structure
- Shared macro header holds `PCbegin` (32'h3000), `PCexc` (32'h4180), and the 2-bit state encodings REQ/HOLD/DRAIN.
- Target selection (priority mux) stays inline.
- Sub-module fetch_hold_buf: single-entry word+valid buffer with load/drop/unload.

## Test plan
- Reset, then release with zero-wait memory: im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; f_valid=1 from cycle 2.
- Ack delayed 3 cycles: im_req and im_addr=0x3000 held stable for 3 cycles; a single f_valid pulse follows, with f_pc=0x3000.
- redirect_pc=0x3100 during a 2-wait fetch of 0x3008: DRAIN is entered, the 0x3008 data is never presented, and the next im_addr is 0x3100.
- stall=1 when the ack for 0x300C arrives: HOLD, f_* unchanged, im_req=0. After stall=0: f_pc=0x300C, and the next request is 0x3010.
- int_req with stall=1 and eret in the same cycle: f_valid=0, next im_addr is 0x4180, and epc is ignored.
- eret with epc=0x3040 while in HOLD: buffer dropped, next im_addr is 0x3040.
- Reset asserted mid-DRAIN: pc=0x3000, im_req=0.
